// File: rtl/v2f_seq_divmod.sv
// Sequential radix-2 restoring divider producing quotient and remainder.
// One iteration per clock; signed mode divides magnitudes and fixes signs on the last step.
module v2f_seq_divmod #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic            neg_q_reg, neg_r_reg, ovf_pend_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic            div_zero_reg, overflow_reg;

  logic            a_neg, b_neg, ovf_in, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] r_step, q_step;

  assign a_neg  = SIGNED && a[WIDTH-1];
  assign b_neg  = SIGNED && b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign ovf_in = SIGNED && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // The shifted partial remainder is below 2*divisor, so bit WIDTH of the
  // trial difference is set exactly when the subtraction would go negative.
  assign shifted = {r_reg, q_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, d_reg};
  assign r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step  = {q_reg[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = b_zero ? DONE : CALC;
      CALC:    if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      d_reg        <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      ovf_pend_reg <= 1'b0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cnt_reg      <= '0;
            q_reg        <= a_mag;
            r_reg        <= '0;
            d_reg        <= b_mag;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            ovf_pend_reg <= ovf_in;
            if (b_zero) begin
              quot_reg     <= '1;
              rem_reg      <= a;
              div_zero_reg <= 1'b1;
              overflow_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg   <= q_step;
          r_reg   <= r_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            cnt_reg      <= '0;
            quot_reg     <= neg_q_reg ? -q_step : q_step;
            rem_reg      <= neg_r_reg ? -r_step : r_step;
            div_zero_reg <= 1'b0;
            overflow_reg <= ovf_pend_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quot      = quot_reg;
  assign rem       = rem_reg;
  assign div_zero  = div_zero_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// Directed bench for v2f_seq_divmod at WIDTH=8: one unsigned and one signed instance.
module tb_v2f_seq_divmod;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid_s;
  logic [1:0] in_ready_s, out_valid_s, dz_s, ov_s;
  logic [7:0] a_s, b_s;
  logic       out_ready;
  logic [7:0] quot_s [2];
  logic [7:0] rem_s  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  v2f_seq_divmod #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s), .b(b_s), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .quot(quot_s[0]), .rem(rem_s[0]), .div_zero(dz_s[0]), .overflow(ov_s[0])
  );

  v2f_seq_divmod #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s), .b(b_s), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .quot(quot_s[1]), .rem(rem_s[1]), .div_zero(dz_s[1]), .overflow(ov_s[1])
  );

  typedef struct {
    int         s;
    logic [7:0] a, b, q, r;
    logic       dz, ov;
    int         lat;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // lat = rising edges after the accept edge until out_valid is seen
  // (0 means the result was registered by the accept edge itself).
  task automatic run_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                        output int lat);
    @(negedge clk);
    chk($sformatf("in_ready_before_%0d", s), 32'(in_ready_s[s]), 32'd1);
    a_s = av; b_s = bv; in_valid_s[s] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[s] = 1'b0;
    a_s = ~av; b_s = ~bv;
    lat = 0;
    while (out_valid_s[s] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid never rose for a=0x%02h b=0x%02h", av, bv);
    end
  endtask

  initial begin
    int lat;
    logic [7:0] hq, hr;

    vecs[0]  = '{0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 8};
    vecs[1]  = '{0, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0, 1'b0, 8};
    vecs[2]  = '{0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8};
    vecs[3]  = '{0, 8'd7,   8'd9,   8'd0,   8'd7,   1'b0, 1'b0, 8};
    vecs[4]  = '{0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 8};
    vecs[5]  = '{0, 8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 1'b0, 8};
    vecs[6]  = '{0, 8'd42,  8'd0,   8'hFF,  8'd42,  1'b1, 1'b0, 0};
    vecs[7]  = '{0, 8'hF9,  8'h02,  8'h7C,  8'h01,  1'b0, 1'b0, 8};
    vecs[8]  = '{1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0, 8};
    vecs[9]  = '{1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0, 8};
    vecs[10] = '{1, 8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0, 1'b0, 8};
    vecs[11] = '{1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0, 8};
    vecs[12] = '{1, 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0, 8};
    vecs[13] = '{1, 8'h80,  8'h80,  8'h01,  8'h00,  1'b0, 1'b0, 8};
    vecs[14] = '{1, 8'h80,  8'h02,  8'hC0,  8'h00,  1'b0, 1'b0, 8};
    vecs[15] = '{1, 8'hF9,  8'h00,  8'hFF,  8'hF9,  1'b1, 1'b0, 0};
    vecs[16] = '{1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 8};

    rst = 1'b1; in_valid_s = 2'b00; a_s = '0; b_s = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_in_ready_%0d", s),  32'(in_ready_s[s]),  32'd1);
      chk($sformatf("rst_out_valid_%0d", s), 32'(out_valid_s[s]), 32'd0);
      chk($sformatf("rst_quot_%0d", s),      32'(quot_s[s]),      32'd0);
      chk($sformatf("rst_rem_%0d", s),       32'(rem_s[s]),       32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      $display("op %0d: s=%0d a=0x%02h b=0x%02h -> q=0x%02h r=0x%02h dz=%0b ov=%0b lat=%0d",
               i, vecs[i].s, vecs[i].a, vecs[i].b, quot_s[vecs[i].s], rem_s[vecs[i].s],
               dz_s[vecs[i].s], ov_s[vecs[i].s], lat);
      chk($sformatf("v%0d_quot", i), 32'(quot_s[vecs[i].s]), 32'(vecs[i].q));
      chk($sformatf("v%0d_rem", i),  32'(rem_s[vecs[i].s]),  32'(vecs[i].r));
      chk($sformatf("v%0d_dz", i),   32'(dz_s[vecs[i].s]),   32'(vecs[i].dz));
      chk($sformatf("v%0d_ov", i),   32'(ov_s[vecs[i].s]),   32'(vecs[i].ov));
      chk($sformatf("v%0d_lat", i),  32'(lat),               32'(vecs[i].lat));
      @(posedge clk); #1;
      chk($sformatf("v%0d_back_idle", i), 32'(in_ready_s[vecs[i].s]), 32'd1);
    end

    // Hold result with out_ready low while in_valid stays high and operands toggle.
    out_ready = 1'b0;
    @(negedge clk);
    a_s = 8'd100; b_s = 8'd7; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (out_valid_s[0] !== 1'b1 && lat < 40) begin
      a_s = a_s + 8'd13; b_s = b_s ^ 8'h5A;
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd8);
    hq = 8'd14; hr = 8'd2;
    for (int c = 0; c < 5; c++) begin
      a_s = a_s + 8'd29; b_s = b_s ^ 8'hA5;
      @(posedge clk); #1;
      $display("hold cycle %0d: out_valid=%0b in_ready=%0b q=%0d r=%0d",
               c, out_valid_s[0], in_ready_s[0], quot_s[0], rem_s[0]);
      chk("hold_out_valid", 32'(out_valid_s[0]), 32'd1);
      chk("hold_in_ready",  32'(in_ready_s[0]),  32'd0);
      chk("hold_quot",      32'(quot_s[0]),      32'(hq));
      chk("hold_rem",       32'(rem_s[0]),       32'(hr));
    end
    in_valid_s[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready",  32'(in_ready_s[0]),  32'd1);
    chk("release_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("idle_keeps_quot",   32'(quot_s[0]),      32'd14);

    // Reset during the 4th CALC cycle aborts the operation.
    @(negedge clk);
    a_s = 8'd100; b_s = 8'd7; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("after abort reset: in_ready=%0b out_valid=%0b q=%0d r=%0d ov1=%0b",
             in_ready_s[0], out_valid_s[0], quot_s[0], rem_s[0], ov_s[1]);
    chk("abort_in_ready",  32'(in_ready_s[0]),  32'd1);
    chk("abort_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("abort_quot",      32'(quot_s[0]),      32'd0);
    chk("abort_rem",       32'(rem_s[0]),       32'd0);
    chk("abort_dz",        32'(dz_s[0]),        32'd0);
    chk("abort_ov_sgn",    32'(ov_s[1]),        32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid_s[0]), 32'd0);

    run_op(0, 8'd200, 8'd3, lat);
    $display("post-reset op: a=200 b=3 -> q=%0d r=%0d lat=%0d", quot_s[0], rem_s[0], lat);
    chk("post_rst_quot", 32'(quot_s[0]), 32'd66);
    chk("post_rst_rem",  32'(rem_s[0]),  32'd2);
    chk("post_rst_lat",  32'(lat),       32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
